// File: rtl/masked_codec_pkg.sv
// Shared constants and helpers for the masked SKINNY S-box host codec.
// LFSR definition, share count and the 4-bit SKINNY S-box table.
package masked_codec_pkg;

  localparam int LFSR_W  = 80;
  localparam int TAP_A   = 79;
  localparam int TAP_B   = 78;
  localparam int TAP_C   = 42;
  localparam int TAP_D   = 41;
  localparam int NSHARES = 3;

  // Nibble i of the table is S(i): C 6 9 0 1 A 2 B 3 8 5 D 4 E 7 F
  localparam logic [63:0] SKINNY_SBOX4 = 64'hF7E4_D583_B2A1_096C;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] s
  );
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {s[LFSR_W-2:0], fb};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_adv80(
    input logic [LFSR_W-1:0] s
  );
    logic [LFSR_W-1:0] t;
    t = s;
    for (int i = 0; i < LFSR_W; i++) begin
      t = lfsr_step(t);
    end
    return t;
  endfunction

  function automatic logic [7:0] skinny_sbox8(input logic [7:0] x);
    logic [5:0] hi;
    logic [5:0] lo;
    hi = {x[7:4], 2'b00};
    lo = {x[3:0], 2'b00};
    return {SKINNY_SBOX4[hi +: 4], SKINNY_SBOX4[lo +: 4]};
  endfunction

endpackage

// File: rtl/codec_result_fifo.sv
// First-word-fall-through result FIFO with an explicit occupancy count.
// Pointers wrap modulo DEPTH; the count register resolves full/empty.
module codec_result_fifo
  import masked_codec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // The credit scheme upstream must make both of these unreachable
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && count_q == '0));

endmodule

// File: rtl/masked_sbox_codec.sv
// Host codec for the 3-share masked SKINNY S-box pair: masks bytes,
// feeds refresh randomness, and recombines results into a stream.
module masked_sbox_codec
  import masked_codec_pkg::*;
#(
  parameter int          LAT   = 3,
  parameter int          DEPTH = 4,
  parameter logic [79:0] SEED  = 80'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [7:0]  sh_in1,
  output logic [7:0]  sh_in2,
  output logic [7:0]  sh_in3,
  output logic [63:0] r_out,
  input  logic [7:0]  sh_out1,
  input  logic [7:0]  sh_out2,
  input  logic [7:0]  sh_out3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  input  logic        seed_load,
  input  logic [79:0] seed
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [LFSR_W-1:0] prng_q, prng_d;
  logic [7:0]        sh1_q, sh1_d;
  logic [7:0]        sh2_q, sh2_d;
  logic [7:0]        sh3_q, sh3_d;
  logic [63:0]       r_q, r_d;
  logic [LAT:0]      v_q, v_d;
  logic [CW-1:0]     infl_q, infl_d;

  logic          accept;
  logic          retire;
  logic          pop;
  logic [7:0]    din;
  logic [7:0]    result;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   credit_used;

  assign accept      = in_valid & in_ready;
  assign retire      = v_q[LAT];
  assign result      = sh_out1 ^ sh_out2 ^ sh_out3;
  assign credit_used = {1'b0, infl_q} + {1'b0, fifo_cnt};
  assign in_ready    = !rst && !seed_load
                    && (credit_used < (CW + 1)'(DEPTH));
  assign out_valid   = fifo_cnt != '0;
  assign pop         = out_valid & out_ready;
  assign out_data    = out_valid ? fifo_head : 8'h00;

  always_comb begin
    prng_d = lfsr_adv80(prng_q);
    if (seed_load) begin
      prng_d = (seed == '0) ? SEED : seed;
    end
    // Idle cycles still emit a fresh sharing of zero
    din   = accept ? in_data : 8'h00;
    sh1_d = prng_q[7:0];
    sh2_d = prng_q[15:8];
    sh3_d = din ^ prng_q[7:0] ^ prng_q[15:8];
    r_d   = prng_q[79:16];
    v_d   = {v_q[LAT-1:0], accept};
    unique case ({accept, retire})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prng_q <= SEED;
      sh1_q  <= '0;
      sh2_q  <= '0;
      sh3_q  <= '0;
      r_q    <= '0;
      v_q    <= '0;
      infl_q <= '0;
    end else begin
      prng_q <= prng_d;
      sh1_q  <= sh1_d;
      sh2_q  <= sh2_d;
      sh3_q  <= sh3_d;
      r_q    <= r_d;
      v_q    <= v_d;
      infl_q <= infl_d;
    end
  end

  assign sh_in1 = sh1_q;
  assign sh_in2 = sh2_q;
  assign sh_in3 = sh3_q;
  assign r_out  = r_q;

  codec_result_fifo #(
    .DEPTH (DEPTH),
    .W     (8),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (retire),
    .wdata (result),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_cnt)
  );

  a_infl_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(retire && !accept && infl_q == '0));

endmodule

// File: tb/tb_masked_sbox_codec.sv
// Bench for masked_sbox_codec: behavioural masked TwoSbox harness,
// scoreboard of expected S-box outputs, and a PRNG reference model.
module tb_masked_sbox_codec;
  import masked_codec_pkg::*;

  localparam int          LAT    = 3;
  localparam int          DEPTH  = 4;
  localparam logic [79:0] SEED_V = 80'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  sh_in1, sh_in2, sh_in3;
  logic [63:0] r_out;
  logic [7:0]  sh_out1, sh_out2, sh_out3;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        seed_load;
  logic [79:0] seed;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int pop_cnt  = 0;

  logic [7:0] sb [$];

  masked_sbox_codec #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .SEED  (SEED_V)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sh_in1    (sh_in1),
    .sh_in2    (sh_in2),
    .sh_in3    (sh_in3),
    .r_out     (r_out),
    .sh_out1   (sh_out1),
    .sh_out2   (sh_out2),
    .sh_out3   (sh_out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .seed_load (seed_load),
    .seed      (seed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] ref_adv80(input logic [79:0] s);
    logic [79:0] t;
    logic fb;
    t = s;
    for (int i = 0; i < 80; i++) begin
      fb = t[79] ^ t[78] ^ t[42] ^ t[41];
      t  = {t[78:0], fb};
    end
    return t;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [63:0] tbl;
    tbl = SKINNY_SBOX4;
    return {tbl[{x[7:4], 2'b00} +: 4], tbl[{x[3:0], 2'b00} +: 4]};
  endfunction

  // Masked TwoSbox stand-in: LAT register stages, output reshared with r_out
  logic [23:0] pipe [LAT];
  always @(posedge clk) begin
    logic [7:0] y, o1, o2;
    y  = ref_sbox(sh_in1 ^ sh_in2 ^ sh_in3);
    o1 = sh_in1 ^ r_out[7:0];
    o2 = sh_in2 ^ r_out[15:8];
    pipe[0] <= {y ^ o1 ^ o2, o2, o1};
    for (int i = 1; i < LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end
  assign sh_out1 = pipe[LAT-1][7:0];
  assign sh_out2 = pipe[LAT-1][15:8];
  assign sh_out3 = pipe[LAT-1][23:16];

  // Monitor on the falling edge: handshakes, shares, PRNG model, scoreboard
  logic [79:0] mp;
  logic [79:0] exp_p;
  logic [7:0]  exp_byte;
  bit          have_exp  = 1'b0;
  bit          prev_hold = 1'b0;
  logic [7:0]  prev_data;

  always @(negedge clk) begin
    bit acc;
    if (rst) begin
      chk("rst_in_ready", {95'd0, in_ready}, 96'd0);
      chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
      chk("rst_regs", {r_out, sh_in3, sh_in2, sh_in1, out_data}, 96'd0);
      sb.delete();
      mp        = SEED_V;
      have_exp  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (have_exp) begin
        chk("prng_bits", {16'd0, r_out, sh_in2, sh_in1}, {16'd0, exp_p});
        chk("share_xor", {88'd0, sh_in1 ^ sh_in2 ^ sh_in3},
            {88'd0, exp_byte});
      end
      if (prev_hold && out_valid) begin
        chk("hold_stable", {88'd0, out_data}, {88'd0, prev_data});
      end
      acc      = in_valid && in_ready;
      exp_p    = mp;
      exp_byte = acc ? in_data : 8'h00;
      have_exp = 1'b1;
      if (seed_load) mp = (seed == '0) ? SEED_V : seed;
      else           mp = ref_adv80(mp);
      if (acc) begin
        sb.push_back(ref_sbox(in_data));
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 96'd1, 96'd0);
        else chk("out_data", {88'd0, out_data}, {88'd0, sb.pop_front()});
        pop_cnt++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic send_byte(input logic [7:0] d, input int budget,
                           output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    ok       = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_pops(input string tag, input int target,
                           input int budget);
    for (int i = 0; i < budget && pop_cnt < target; i++) begin
      @(posedge clk);
    end
    #1;
    chk(tag, 96'(pop_cnt), 96'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          lat;
    int          nacc;
    int          p0;
    int          a0;
    logic [79:0] m;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {95'd0, in_ready}, 96'd1);
    @(posedge clk);
    #1;

    // Single byte latency and value
    out_ready = 1'b1;
    send_byte(8'h10, 10, ok);
    chk("t1_accept", {95'd0, ok}, 96'd1);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && out_valid) begin
        lat = k;
        chk("t1_value", {88'd0, out_data}, {88'd0, 8'h6C});
      end
    end
    chk("t1_latency", 96'(lat), 96'(LAT + 1));

    // Stream all byte values
    p0   = pop_cnt;
    nacc = 0;
    for (int b = 0; b < 256; b++) begin
      send_byte(8'(b), 40, ok);
      if (ok) nacc++;
    end
    chk("t2_accepts", 96'(nacc), 96'd256);
    wait_pops("t2_pops", p0 + nacc, 200);

    // Credit limit with consumer stalled
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    p0   = pop_cnt;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'hA0 + 8'(i), 8, ok);
      if (ok) nacc++;
    end
    chk("t3_accepts", 96'(nacc), 96'(DEPTH));
    @(negedge clk);
    chk("t3_blocked", {95'd0, in_ready}, 96'd0);
    chk("t3_full_valid", {95'd0, out_valid}, 96'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_pops("t3_pops", p0 + DEPTH, 20);
    send_byte(8'h55, 10, ok);
    chk("t3_resume", {95'd0, ok}, 96'd1);
    wait_pops("t3_last_pop", p0 + DEPTH + 1, 20);

    // Reset with results buffered and in flight
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    send_byte(8'h11, 10, ok);
    send_byte(8'h22, 10, ok);
    repeat (LAT + 2) @(posedge clk);
    #1;
    send_byte(8'h33, 10, ok);
    send_byte(8'h44, 10, ok);
    chk("t4_fill_blocked", {95'd0, in_ready}, 96'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    p0 = pop_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_no_out", {95'd0, out_valid}, 96'd0);
    end
    chk("t4_no_pops", 96'(pop_cnt), 96'(p0));

    // Reseed: zero falls back to SEED, then a user seed
    @(posedge clk);
    #1;
    a0        = acc_cnt;
    seed_load = 1'b1;
    seed      = '0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    @(negedge clk);
    chk("t5_ready_low", {95'd0, in_ready}, 96'd0);
    @(posedge clk);
    #1 seed = 80'hABC;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    in_valid  = 1'b0;
    chk("t5_no_accept", 96'(acc_cnt - a0), 96'd0);
    m = 80'hABC;
    @(posedge clk);
    #1 chk("t5_r0", {32'd0, r_out}, {32'd0, m[79:16]});
    m = ref_adv80(m);
    @(posedge clk);
    #1 chk("t5_r1", {32'd0, r_out}, {32'd0, m[79:16]});
    m = ref_adv80(m);
    @(posedge clk);
    #1 chk("t5_r2", {32'd0, r_out}, {32'd0, m[79:16]});

    repeat (10) @(posedge clk);
    #1 chk("sb_drained", 96'(sb.size()), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
